multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and write-back around the shared ALU, the immediate generator, the register file and the instruction/data memory ports.
- Latches the opcode in decode and drives datapath select/enable strobes.
- Absorbs cache stalls and keeps cycle and retired-instruction counters.

Parameters:
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
instruction  input  32  instruction register contents (valid from ID onward)
icache_stall  input  1  instruction fetch not complete this cycle
dcache_stall  input  1  data access not complete this cycle
branch_taken  input  1  ALU comparison result for current branch (valid in EX)
state  output  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4
imem_req  output  1  instruction fetch request
ir_write  output  1  load instruction register
pc_write  output  1  update PC
pc_sel  output  2  00 pc+4, 01 pc+imm, 10 ALU result with bit0 cleared
alu_src_a  output  2  00 rs1, 01 pc, 10 zero
alu_src_b  output  1  0 rs2, 1 immediate
dmem_read  output  1  data load request
dmem_write  output  1  data store request
reg_write  output  1  register file write enable
wb_sel  output  2  00 ALU, 01 memory, 10 link (pc+4 captured at jump)
illegal  output  1  one-cycle pulse: unsupported opcode
cycle_cnt  output  CNT_W  cycles since reset
instret_cnt  output  CNT_W  retired instructions since reset

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction): state=IF, op_q=0, both counters=0. All strobes follow from state IF.
  - imem_req=1; all other strobes 0 except ir_write, which mirrors !icache_stall.
- Outputs are Moore-style: combinational from state and op_q, plus the stall inputs and branch_taken where noted. Any strobe not listed below is 0.
- IF:
  - imem_req=1; ir_write=!icache_stall.
  - Stay in IF while icache_stall; otherwise go to ID.
- ID:
  - op_q <= instruction[6:0].
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
  - Unsupported opcode: illegal=1 this cycle, no counter increment, next state IF. PC is not written; trap handling is outside this block.
  - Supported opcode: next state EX.
- EX operand selects (op_q):
  - R: a=rs1, b=rs2.
  - I-ALU, load, store, jalr: a=rs1, b=imm.
  - lui: a=zero, b=imm.
  - auipc: a=pc, b=imm.
  - branch: a=rs1, b=rs2.
  - jal: a=pc, b=imm.
- EX transitions and strobes:
  - branch: pc_write=1, pc_sel = branch_taken ? 01 : 00; retire; next state IF.
  - jal: pc_write=1, pc_sel=01; next state WB.
  - jalr: pc_write=1, pc_sel=10; next state WB.
  - load, store: next state MEM.
  - other supported opcodes: next state WB.
- MEM:
  - dmem_read=1 for load; dmem_write=1 for store. Held constant while dcache_stall.
  - On !dcache_stall: load goes to WB; store asserts pc_write=1, pc_sel=00, retires, next state IF.
- WB:
  - reg_write=1; wb_sel = 01 for load, 10 for jal/jalr, 00 otherwise.
  - Non-jump opcodes also assert pc_write=1, pc_sel=00.
  - Retire; next state IF.
- Latency with no stalls: branch 3 cycles; store, R, I-ALU, lui, auipc, jal, jalr 4 cycles; load 5 cycles; illegal 2 cycles.
- Each stall cycle adds exactly one cycle in IF or MEM.
- Counters:
  - cycle_cnt +1 every clock after reset.
  - instret_cnt +1 on each retiring transition to IF.
  - Both wrap modulo 2^CNT_W with no saturation or flag.
- Unreachable state encodings 5-7: treated as IF (all outputs as IF) and next state IF.

Test Plan:
- Reset, then R-type 0x002081B3 with no stalls -> state sequence 0,1,2,4,0; reg_write=1 only in WB; instret_cnt=1 and cycle_cnt=4 after the return to IF.
- Load 0x0000A103 with dcache_stall high for 3 MEM cycles -> dmem_read held 4 cycles; WB wb_sel=01; total 8 cycles; no reg_write during the stall.
- Branch 0xFE000EE3 in EX: branch_taken=1 -> pc_write=1, pc_sel=01. Repeat with branch_taken=0 -> pc_sel=00. Both return to IF after 3 cycles with no reg_write.
- jal 0x008000EF -> EX: pc_write=1, pc_sel=01, alu_src_a=01. WB: reg_write=1, wb_sel=10, pc_write=0.
- Opcode 0x0000007F -> illegal pulses for 1 cycle in ID; back in IF next cycle; instret_cnt unchanged.
- rst asserted mid-MEM of a store with dcache_stall=1 -> state=0 immediately (asynchronously), dmem_write=0, counters=0. With CNT_W=4 and no further resets, cycle_cnt reads 15 then 0 on the next clock.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundle between the multi-cycle RV32I control FSM and its
//               datapath / memory ports.
//   master modport (controller side):
//     in  : instruction, icache_stall, dcache_stall, branch_taken
//     out : state, imem_req, ir_write, pc_write, pc_sel, alu_src_a,
//           alu_src_b, dmem_read, dmem_write, reg_write, wb_sel, illegal,
//           cycle_cnt, instret_cnt
//   slave modport (datapath side): same signals, opposite directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instruction;
  logic             icache_stall;
  logic             dcache_stall;
  logic             branch_taken;
  logic [2:0]       state;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic [1:0]       alu_src_a;
  logic             alu_src_b;
  logic             dmem_read;
  logic             dmem_write;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             illegal;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    input  instruction, icache_stall, dcache_stall, branch_taken,
    output state, imem_req, ir_write, pc_write, pc_sel, alu_src_a,
           alu_src_b, dmem_read, dmem_write, reg_write, wb_sel, illegal,
           cycle_cnt, instret_cnt
  );

  modport slave (
    output instruction, icache_stall, dcache_stall, branch_taken,
    input  state, imem_req, ir_write, pc_write, pc_sel, alu_src_a,
           alu_src_b, dmem_read, dmem_write, reg_write, wb_sel, illegal,
           cycle_cnt, instret_cnt
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Main control FSM of the multi-cycle RV32I core. Sequences
//               IF/ID/EX/MEM/WB, latches the opcode in ID, drives datapath
//               select/enable strobes, absorbs cache stalls and keeps the
//               cycle and retired-instruction counters.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : multicycle_ctrl_if.master (instruction, stalls, branch_taken in;
//         state, strobes, selects and counters out)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [6:0]       r_op;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  logic             w_retire;
  logic             w_supported;
  logic             w_imem_req;
  logic             w_ir_write;
  logic             w_pc_write;
  logic [1:0]       w_pc_sel;
  logic [1:0]       w_alu_src_a;
  logic             w_alu_src_b;
  logic             w_dmem_read;
  logic             w_dmem_write;
  logic             w_reg_write;
  logic [1:0]       w_wb_sel;
  logic             w_illegal;
  logic             w_unused;

  // Only the opcode field matters to the controller.
  assign w_unused = ^bus.instruction[31:7];

  // Legality is judged on the live instruction in ID, before op is latched.
  always_comb begin
    case (bus.instruction[6:0])
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_supported = 1'b1;
      default:                           w_supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IF;
      r_op          <= 7'd0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if (w_retire) begin
        r_instret_cnt <= r_instret_cnt + CNT_ONE;
      end
      if (r_state == S_ID) begin
        r_op <= bus.instruction[6:0];
      end
    end
  end

  always_comb begin
    w_next_state = S_IF;
    w_retire     = 1'b0;
    w_imem_req   = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_sel     = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 1'b0;
    w_dmem_read  = 1'b0;
    w_dmem_write = 1'b0;
    w_reg_write  = 1'b0;
    w_wb_sel     = 2'b00;
    w_illegal    = 1'b0;

    case (r_state)
      S_IF: begin
        w_imem_req   = 1'b1;
        w_ir_write   = !bus.icache_stall;
        w_next_state = bus.icache_stall ? S_IF : S_ID;
      end

      S_ID: begin
        // Illegal opcodes drop straight back to IF; trap entry lives elsewhere.
        w_illegal    = !w_supported;
        w_next_state = w_supported ? S_EX : S_IF;
      end

      S_EX: begin
        w_next_state = S_WB;
        case (r_op)
          OP_R: begin
            w_alu_src_a = 2'b00;
            w_alu_src_b = 1'b0;
          end
          OP_BR: begin
            w_alu_src_a  = 2'b00;
            w_alu_src_b  = 1'b0;
            w_pc_write   = 1'b1;
            w_pc_sel     = bus.branch_taken ? 2'b01 : 2'b00;
            w_retire     = 1'b1;
            w_next_state = S_IF;
          end
          OP_LUI: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 1'b1;
          end
          OP_AUIPC: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 1'b1;
          end
          OP_JAL: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 1'b1;
            w_pc_write  = 1'b1;
            w_pc_sel    = 2'b01;
          end
          OP_JALR: begin
            w_alu_src_a = 2'b00;
            w_alu_src_b = 1'b1;
            w_pc_write  = 1'b1;
            w_pc_sel    = 2'b10;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_src_a  = 2'b00;
            w_alu_src_b  = 1'b1;
            w_next_state = S_MEM;
          end
          default: begin
            // I-ALU
            w_alu_src_a = 2'b00;
            w_alu_src_b = 1'b1;
          end
        endcase
      end

      S_MEM: begin
        // Requests stay asserted for the whole stall so the cache sees a
        // stable access.
        w_dmem_read  = (r_op == OP_LOAD);
        w_dmem_write = (r_op == OP_STORE);
        if (bus.dcache_stall) begin
          w_next_state = S_MEM;
        end else if (r_op == OP_LOAD) begin
          w_next_state = S_WB;
        end else begin
          w_pc_write   = 1'b1;
          w_pc_sel     = 2'b00;
          w_retire     = 1'b1;
          w_next_state = S_IF;
        end
      end

      S_WB: begin
        w_reg_write = 1'b1;
        if (r_op == OP_LOAD) begin
          w_wb_sel = 2'b01;
        end else if ((r_op == OP_JAL) || (r_op == OP_JALR)) begin
          w_wb_sel = 2'b10;
        end else begin
          w_wb_sel = 2'b00;
        end
        // Jumps already redirected the PC in EX.
        if ((r_op != OP_JAL) && (r_op != OP_JALR)) begin
          w_pc_write = 1'b1;
          w_pc_sel   = 2'b00;
        end
        w_retire     = 1'b1;
        w_next_state = S_IF;
      end

      default: begin
        // Encodings 5-7 behave like IF but always return to IF.
        w_imem_req   = 1'b1;
        w_ir_write   = !bus.icache_stall;
        w_next_state = S_IF;
      end
    endcase
  end

  assign bus.state       = r_state;
  assign bus.imem_req    = w_imem_req;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.alu_src_a   = w_alu_src_a;
  assign bus.alu_src_b   = w_alu_src_b;
  assign bus.dmem_read   = w_dmem_read;
  assign bus.dmem_write  = w_dmem_write;
  assign bus.reg_write   = w_reg_write;
  assign bus.wb_sel      = w_wb_sel;
  assign bus.illegal     = w_illegal;
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. A schedule of
//               expected phases is built per instruction from its class and
//               stall counts; each cycle's strobes and counters are compared
//               against values derived from the instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  typedef enum int {C_R, C_IALU, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR,
                    C_LUI, C_AUIPC, C_ILL} cls_t;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } outs_t;

  typedef struct {
    int   st;
    logic is;
    logic ds;
  } phase_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int unsigned m_cycle   = 0;
  int unsigned m_instret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_IALU;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  // Expected strobes for one phase of an instruction of class c.
  function automatic outs_t model_outs(input int st, input logic is,
                                       input logic ds, input cls_t c,
                                       input logic tk);
    outs_t o;
    o = '0;
    o.state = 3'(st);
    if (st == 0) begin
      o.imem_req = 1'b1;
      o.ir_write = !is;
    end else if (st == 1) begin
      o.illegal = (c == C_ILL);
    end else if (st == 2) begin
      if (c == C_R || c == C_BR) begin
        o.alu_src_a = 2'd0; o.alu_src_b = 1'b0;
      end else if (c == C_LUI) begin
        o.alu_src_a = 2'd2; o.alu_src_b = 1'b1;
      end else if (c == C_AUIPC || c == C_JAL) begin
        o.alu_src_a = 2'd1; o.alu_src_b = 1'b1;
      end else begin
        o.alu_src_a = 2'd0; o.alu_src_b = 1'b1;
      end
      if (c == C_BR)   begin o.pc_write = 1'b1; o.pc_sel = tk ? 2'd1 : 2'd0; end
      if (c == C_JAL)  begin o.pc_write = 1'b1; o.pc_sel = 2'd1; end
      if (c == C_JALR) begin o.pc_write = 1'b1; o.pc_sel = 2'd2; end
    end else if (st == 3) begin
      o.dmem_read  = (c == C_LOAD);
      o.dmem_write = (c == C_STORE);
      if (c == C_STORE && !ds) begin o.pc_write = 1'b1; o.pc_sel = 2'd0; end
    end else begin
      o.reg_write = 1'b1;
      o.wb_sel = (c == C_LOAD) ? 2'd1 : ((c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0);
      if (c != C_JAL && c != C_JALR) begin o.pc_write = 1'b1; o.pc_sel = 2'd0; end
    end
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o.state      = bus.state;
    o.imem_req   = bus.imem_req;
    o.ir_write   = bus.ir_write;
    o.pc_write   = bus.pc_write;
    o.pc_sel     = bus.pc_sel;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.dmem_read  = bus.dmem_read;
    o.dmem_write = bus.dmem_write;
    o.reg_write  = bus.reg_write;
    o.wb_sel     = bus.wb_sel;
    o.illegal    = bus.illegal;
    return o;
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered at a negedge, leaves at the next negedge.
  task automatic step(input string tag, input logic [31:0] instr,
                      input phase_t p, input logic tk);
    cls_t  c;
    outs_t e;
    outs_t o;
    logic  retire;
    c = classify(instr[6:0]);
    bus.instruction  = instr;
    bus.icache_stall = p.is;
    bus.dcache_stall = p.ds;
    bus.branch_taken = tk;
    #1;
    e = model_outs(p.st, p.is, p.ds, c, tk);
    o = observed();
    check_vec({tag, "_outs"}, 32'(o), 32'(e));
    check_vec({tag, "_cycle"}, 32'(bus.cycle_cnt), 32'(CNT_W'(m_cycle)));
    check_vec({tag, "_instret"}, 32'(bus.instret_cnt), 32'(CNT_W'(m_instret)));
    retire = (p.st == 2 && c == C_BR) || (p.st == 3 && c == C_STORE && !p.ds) ||
             (p.st == 4);
    @(posedge clk);
    m_cycle++;
    if (retire) m_instret++;
    @(negedge clk);
  endtask

  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input int n_is, input int n_ds, input logic tk);
    phase_t q[$];
    cls_t   c;
    c = classify(instr[6:0]);
    for (int i = 0; i < n_is; i++) q.push_back('{0, 1'b1, 1'b0});
    q.push_back('{0, 1'b0, 1'b0});
    q.push_back('{1, 1'b0, 1'b0});
    if (c != C_ILL) begin
      q.push_back('{2, 1'b0, 1'b0});
      if (c == C_LOAD || c == C_STORE) begin
        for (int i = 0; i < n_ds; i++) q.push_back('{3, 1'b0, 1'b1});
        q.push_back('{3, 1'b0, 1'b0});
      end
      if (c != C_BR && c != C_STORE) q.push_back('{4, 1'b0, 1'b0});
    end
    foreach (q[i]) step(tag, instr, q[i], tk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 32'h0000_0013, '{0, 1'b1, 1'b0}, 1'b0);
  endtask

  logic [6:0] ops [0:10];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111,
            7'b0001011};
    rst = 1'b1;
    bus.instruction  = 32'h0;
    bus.icache_stall = 1'b1;
    bus.dcache_stall = 1'b0;
    bus.branch_taken = 1'b0;
    @(negedge clk);
    #1;
    check_vec("reset_state", 32'(bus.state), 32'd0);
    check_vec("reset_imem_req", 32'(bus.imem_req), 32'd1);
    check_vec("reset_cycle", 32'(bus.cycle_cnt), 32'd0);
    check_vec("reset_instret", 32'(bus.instret_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sequences
    run_instr("r_type", 32'h0020_81B3, 0, 0, 1'b0);
    run_instr("load_stall", 32'h0000_A103, 0, 3, 1'b0);
    run_instr("branch_taken", 32'hFE00_0EE3, 0, 0, 1'b1);
    run_instr("branch_not", 32'hFE00_0EE3, 0, 0, 1'b0);
    run_instr("jal", 32'h0080_00EF, 0, 0, 1'b0);
    run_instr("illegal", 32'h0000_007F, 0, 0, 1'b0);
    run_instr("istall_r", 32'h0020_81B3, 2, 0, 1'b0);
    run_instr("jalr", 32'h0000_8067, 1, 0, 1'b1);
    run_instr("lui", 32'h1234_50B7, 0, 0, 1'b0);
    run_instr("auipc", 32'h0000_1097, 0, 0, 1'b0);
    run_instr("store", 32'h0020_A023, 0, 2, 1'b0);

    // Randomized instruction mix
    for (int k = 0; k < 60; k++) begin
      logic [31:0] ins;
      ins = {$urandom_range(0, 32'h01FF_FFFF), 7'b0};
      ins[24:0] = 25'($urandom);
      ins[6:0] = ops[$urandom_range(0, 10)];
      run_instr("random", ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a stalled store
    step("st_if", 32'h0020_A023, '{0, 1'b0, 1'b0}, 1'b0);
    step("st_id", 32'h0020_A023, '{1, 1'b0, 1'b0}, 1'b0);
    step("st_ex", 32'h0020_A023, '{2, 1'b0, 1'b0}, 1'b0);
    step("st_mem", 32'h0020_A023, '{3, 1'b0, 1'b1}, 1'b0);
    bus.dcache_stall = 1'b1;
    #1;
    check_vec("pre_rst_dmem_write", 32'(bus.dmem_write), 32'd1);
    rst = 1'b1;
    #1;
    check_vec("arst_state", 32'(bus.state), 32'd0);
    check_vec("arst_dmem_write", 32'(bus.dmem_write), 32'd0);
    check_vec("arst_cycle", 32'(bus.cycle_cnt), 32'd0);
    check_vec("arst_instret", 32'(bus.instret_cnt), 32'd0);
    m_cycle   = 0;
    m_instret = 0;
    bus.icache_stall = 1'b1;
    bus.dcache_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Counter wrap at CNT_W=4
    idle(15);
    #1;
    check_vec("cycle_cnt_15", 32'(bus.cycle_cnt), 32'd15);
    @(posedge clk);
    m_cycle++;
    #1;
    check_vec("cycle_cnt_wrap", 32'(bus.cycle_cnt), 32'd0);
    @(negedge clk);
    run_instr("post_wrap", 32'h0020_81B3, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
